seq_magnitude_comparator: RTL
=============================

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per clock cycle.
REQ-003 SHALL require WIDTH to be an integer multiple of CHUNK, with WIDTH >= CHUNK >= 1; NCHUNK = WIDTH/CHUNK.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port start, input, 1, request to begin a comparison.
REQ-007 SHALL have port signed_mode, input, 1: 1 = two's-complement comparison, 0 = unsigned.
REQ-008 SHALL have port A, input, WIDTH, first operand.
REQ-009 SHALL have port B, input, WIDTH, second operand.
REQ-010 SHALL have port busy, output, 1, high while a comparison is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking a new result.
REQ-012 SHALL have ports EQ, AGB, ALB, output, 1 each: registered result flags for A==B, A>B and A<B.

Function
REQ-013 SHALL implement an FSM with states IDLE, COMPARE and DONE.
REQ-014 SHALL accept start only when busy=0 (state IDLE or DONE).
REQ-015 On acceptance, SHALL latch A, B and signed_mode, set the chunk index to 0 (most significant chunk) and enter COMPARE.
REQ-016 SHALL ignore start, A, B and signed_mode while in COMPARE; the latched values SHALL be used throughout.
REQ-017 In COMPARE, SHALL evaluate one CHUNK-wide slice per cycle, MSB first; chunk k covers bits [WIDTH-1-k*CHUNK -: CHUNK].
REQ-018 When signed_mode=1, SHALL invert the operand MSB within chunk 0 before comparing it; all other chunks SHALL be compared unsigned.
REQ-019 If the evaluated chunks differ, SHALL set AGB or ALB from that chunk's ordering, clear the other two flags and enter DONE (early termination).
REQ-020 If the chunks are equal and k < NCHUNK-1, SHALL increment k and stay in COMPARE.
REQ-021 If the chunks are equal and k = NCHUNK-1, SHALL set EQ=1, clear AGB and ALB, and enter DONE.
REQ-022 Latency: for a deciding chunk k, done SHALL be high in the cycle after the (k+1)th rising edge following the edge that accepted start; the maximum is NCHUNK edges (equality).
REQ-023 done SHALL be high for exactly one cycle, in state DONE; DONE SHALL move to IDLE, or to COMPARE if start is accepted in that cycle.
REQ-024 busy SHALL be 1 exactly in COMPARE.
REQ-025 EQ, AGB and ALB SHALL change only on the edge entering DONE and SHALL hold otherwise, including across a new start, until the next result.
REQ-026 After the first result, exactly one of EQ, AGB and ALB SHALL be 1.
REQ-027 When CHUNK = WIDTH, SHALL produce its result with a latency of 1 edge.

Reset
REQ-028 With rst=1 at a rising edge, SHALL force state IDLE, busy=0, done=0, EQ=AGB=ALB=0, chunk index 0, and clear the latched operands.
REQ-029 rst SHALL take priority over start and SHALL abort an in-progress comparison without any done pulse.
REQ-030 start asserted in the same cycle as rst SHALL be ignored.

Verification (WIDTH=16, CHUNK=4)
REQ-031 The bench SHALL apply rst for 2 cycles -> busy=done=EQ=AGB=ALB=0.
REQ-032 The bench SHALL apply A=0x1234, B=0x1234, unsigned, start -> busy for 4 cycles, done 4 edges after acceptance, EQ=1.
REQ-033 The bench SHALL apply A=0x8000, B=0x7FFF, unsigned -> done after 1 edge, AGB=1; repeat with signed_mode=1 -> ALB=1.
REQ-034 The bench SHALL apply A=0x0001, B=0x0010, unsigned -> done after 3 edges (chunk 2 decides), ALB=1.
REQ-035 The bench SHALL toggle start and operands while busy -> ignored and the original result is produced; start in the DONE cycle is accepted back-to-back.
REQ-036 The bench SHALL assert rst during chunk 2 of an equal-operand compare -> no done pulse, all outputs 0 on the following cycle.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: walks the operands one CHUNK-wide slice per
// clock, most significant slice first, and stops at the first slice that differs.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             AGB,
    output logic             ALB
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] LAST_IDX = KW'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    generate
        if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sign_q, sign_d;
    logic [KW-1:0]     idx_q, idx_d;
    logic              eq_q, eq_d;
    logic              agb_q, agb_d;
    logic              alb_q, alb_d;

    logic [CHUNK-1:0]  a_chunk [NCHUNK];
    logic [CHUNK-1:0]  b_chunk [NCHUNK];
    logic [CHUNK-1:0]  a_cur;
    logic [CHUNK-1:0]  b_cur;
    logic [CHUNK-1:0]  sign_flip;
    logic              accept;

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
        assign a_chunk[gi] = a_q[WIDTH-1-gi*CHUNK -: CHUNK];
        assign b_chunk[gi] = b_q[WIDTH-1-gi*CHUNK -: CHUNK];
    end

    // Flipping the sign bit of the top slice maps two's-complement order onto
    // unsigned order; lower slices keep their plain unsigned weight.
    assign sign_flip = (sign_q && (idx_q == '0)) ? MSB_MASK : '0;
    assign a_cur     = a_chunk[idx_q] ^ sign_flip;
    assign b_cur     = b_chunk[idx_q] ^ sign_flip;
    assign accept    = start && (state_q != COMPARE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        agb_d   = agb_q;
        alb_d   = alb_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    sign_d  = signed_mode;
                    idx_d   = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a_cur != b_cur) begin
                    eq_d    = 1'b0;
                    agb_d   = (a_cur > b_cur);
                    alb_d   = (a_cur < b_cur);
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    eq_d    = 1'b1;
                    agb_d   = 1'b0;
                    alb_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            agb_q   <= 1'b0;
            alb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            agb_q   <= agb_d;
            alb_q   <= alb_d;
        end
    end

    assign busy = (state_q == COMPARE);
    assign done = (state_q == DONE);
    assign EQ   = eq_q;
    assign AGB  = agb_q;
    assign ALB  = alb_q;

endmodule
